// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_pkg
// Purpose  : Shared define package for the decode/execute slice and the
//            register file. It holds the default widths, the opcode
//            encodings and the opcode class predicates.
// Revision : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    localparam int c_DSIZE = 16;
    localparam int c_RSIZE = 4;
    localparam int c_ASIZE = 16;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_SLL = 4'd4,
        OP_SRL = 4'd5,
        OP_SRA = 4'd6,
        OP_RL  = 4'd7,
        OP_LW  = 4'd8,
        OP_SW  = 4'd9,
        OP_LHB = 4'd10,
        OP_LLB = 4'd11,
        OP_BR  = 4'd12,
        OP_J   = 4'd13,
        OP_JAL = 4'd14,
        OP_HLT = 4'd15
    } opcode_e;

    // Opcodes 0-7 are the ALU group.
    function automatic logic is_alu(input logic [3:0] op);
        return (op[3] == 1'b0);
    endfunction

    // Shift and rotate ops carry an unsigned shift amount in the rs2 field.
    function automatic logic is_shift(input logic [3:0] op);
        return (op[3:2] == 2'b01);
    endfunction

    // Ops whose low nibble is a signed offset.
    function automatic logic is_off4(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_BR);
    endfunction

    // Byte-immediate loads.
    function automatic logic is_byte_imm(input logic [3:0] op);
        return (op == OP_LHB) || (op == OP_LLB);
    endfunction

    // Jumps carry a signed 12-bit offset.
    function automatic logic is_jump(input logic [3:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

    // Ops that write a destination register.
    function automatic logic writes_rd(input logic [3:0] op);
        return is_alu(op) || (op == OP_LW) || is_byte_imm(op) || (op == OP_JAL);
    endfunction

    // Ops that read the second port from the rd field instead of rs2.
    function automatic logic rd_on_port2(input logic [3:0] op);
        return (op == OP_SW) || (op == OP_BR);
    endfunction

    // Ops that actually consume the port-1 operand (rs1).
    function automatic logic uses_port1(input logic [3:0] op);
        return is_alu(op) || (op == OP_LW) || (op == OP_SW) || (op == OP_BR);
    endfunction

    // Ops that actually consume the port-2 operand; shifts take an
    // immediate amount there, so only the reg-reg ALU ops read rs2.
    function automatic logic uses_port2(input logic [3:0] op);
        return (op[3:2] == 2'b00) || rd_on_port2(op);
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_decode.sv
`default_nettype none
// ============================================================================
// Module   : id_decode
// Purpose  : Purely combinational instruction decoder. It produces the
//            register read addresses, the destination register, the
//            extended immediate, the control bits and the operand-use flags.
// Revision : 1.0 - initial release
// ============================================================================
module id_decode
    import id_ex_stage_pkg::*;
#(
    parameter int DSIZE = c_DSIZE,
    parameter int RSIZE = c_RSIZE
) (
    input  logic [DSIZE-1:0] i_instr,
    output logic [3:0]       o_op,
    output logic [RSIZE-1:0] o_raddr1,
    output logic [RSIZE-1:0] o_raddr2,
    output logic [RSIZE-1:0] o_rd,
    output logic [DSIZE-1:0] o_imm,
    output logic             o_reg_wen,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_is_jal,
    output logic             o_use1,
    output logic             o_use2
);

    logic [RSIZE-1:0] w_rd_field;
    logic [RSIZE-1:0] w_rs1_field;
    logic [RSIZE-1:0] w_rs2_field;

    assign o_op        = i_instr[15:12];
    assign w_rd_field  = RSIZE'(i_instr[11:8]);
    assign w_rs1_field = RSIZE'(i_instr[7:4]);
    assign w_rs2_field = RSIZE'(i_instr[3:0]);

    assign o_raddr1    = w_rs1_field;
    assign o_raddr2    = rd_on_port2(o_op) ? w_rd_field : w_rs2_field;

    // JAL links into the top register; everything else names rd directly.
    assign o_is_jal    = (o_op == OP_JAL);
    assign o_rd        = o_is_jal ? {RSIZE{1'b1}} : w_rd_field;

    // R0 is hardwired, so a write aimed at it is dropped here.
    assign o_reg_wen   = writes_rd(o_op) && (o_rd != '0);
    assign o_mem_read  = (o_op == OP_LW);
    assign o_mem_write = (o_op == OP_SW);
    assign o_use1      = uses_port1(o_op);
    assign o_use2      = uses_port2(o_op);

    // Immediate formation by opcode class; classes without an immediate give 0.
    always_comb begin
        o_imm = '0;
        if (is_off4(o_op)) begin
            o_imm = {{(DSIZE-4){i_instr[3]}}, i_instr[3:0]};
        end else if (is_shift(o_op)) begin
            o_imm = {{(DSIZE-4){1'b0}}, i_instr[3:0]};
        end else if (is_byte_imm(o_op)) begin
            o_imm = {{(DSIZE-8){1'b0}}, i_instr[7:0]};
        end else if (is_jump(o_op)) begin
            o_imm = {{(DSIZE-12){i_instr[11]}}, i_instr[11:0]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : Decode stage plus the ID/EX pipeline register. It detects the
//            load-use hazard against the instruction in EX, stalls the front
//            end for one cycle and injects bubbles on stall, flush or an
//            empty decode slot.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DSIZE = c_DSIZE,
    parameter int RSIZE = c_RSIZE,
    parameter int ASIZE = c_ASIZE
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [DSIZE-1:0] IfInstr,
    input  logic             IfValid,
    input  logic [ASIZE-1:0] IfPcNext,
    input  logic             Flush,
    output logic [RSIZE-1:0] RAddr1,
    output logic [RSIZE-1:0] RAddr2,
    input  logic [DSIZE-1:0] RData1,
    input  logic [DSIZE-1:0] RData2,
    output logic             Stall,
    output logic             ExValid,
    output logic [3:0]       ExOp,
    output logic [RSIZE-1:0] ExRd,
    output logic [DSIZE-1:0] ExA,
    output logic [DSIZE-1:0] ExB,
    output logic [DSIZE-1:0] ExImm,
    output logic             ExRegWen,
    output logic             ExMemRead,
    output logic             ExMemWrite,
    output logic [ASIZE-1:0] ExPcNext
);

    logic [3:0]       w_op;
    logic [RSIZE-1:0] w_rd;
    logic [DSIZE-1:0] w_imm;
    logic             w_reg_wen;
    logic             w_mem_read;
    logic             w_mem_write;
    logic             w_is_jal;
    logic             w_use1;
    logic             w_use2;
    logic [DSIZE-1:0] w_pc_data;
    logic [DSIZE-1:0] w_a;
    logic             w_hazard;
    logic             w_bubble;

    logic             r_ex_valid;
    logic [3:0]       r_ex_op;
    logic [RSIZE-1:0] r_ex_rd;
    logic [DSIZE-1:0] r_ex_a;
    logic [DSIZE-1:0] r_ex_b;
    logic [DSIZE-1:0] r_ex_imm;
    logic             r_ex_reg_wen;
    logic             r_ex_mem_read;
    logic             r_ex_mem_write;
    logic [ASIZE-1:0] r_ex_pc_next;

    id_decode #(
        .DSIZE (DSIZE),
        .RSIZE (RSIZE)
    ) u_decode (
        .i_instr     (IfInstr),
        .o_op        (w_op),
        .o_raddr1    (RAddr1),
        .o_raddr2    (RAddr2),
        .o_rd        (w_rd),
        .o_imm       (w_imm),
        .o_reg_wen   (w_reg_wen),
        .o_mem_read  (w_mem_read),
        .o_mem_write (w_mem_write),
        .o_is_jal    (w_is_jal),
        .o_use1      (w_use1),
        .o_use2      (w_use2)
    );

    // The link address goes onto the A operand, so fit the PC to the datapath.
    if (ASIZE >= DSIZE) begin : g_pc_trunc
        assign w_pc_data = IfPcNext[DSIZE-1:0];
    end else begin : g_pc_zext
        assign w_pc_data = {{(DSIZE-ASIZE){1'b0}}, IfPcNext};
    end

    assign w_a = w_is_jal ? w_pc_data : RData1;

    // A load in EX whose target feeds an operand the decode slot really uses.
    assign w_hazard = r_ex_valid && r_ex_mem_read && (r_ex_rd != '0) && IfValid &&
                      ((w_use1 && (r_ex_rd == RAddr1)) ||
                       (w_use2 && (r_ex_rd == RAddr2)));

    // A taken branch squashes the decode slot anyway, so it overrides the stall.
    assign Stall    = w_hazard && !Flush;
    assign w_bubble = Flush || w_hazard || !IfValid;

    // ID/EX register: bubble (all zero) or the freshly decoded instruction.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_ex_valid     <= 1'b0;
            r_ex_op        <= '0;
            r_ex_rd        <= '0;
            r_ex_a         <= '0;
            r_ex_b         <= '0;
            r_ex_imm       <= '0;
            r_ex_reg_wen   <= 1'b0;
            r_ex_mem_read  <= 1'b0;
            r_ex_mem_write <= 1'b0;
            r_ex_pc_next   <= '0;
        end else if (w_bubble) begin
            r_ex_valid     <= 1'b0;
            r_ex_op        <= '0;
            r_ex_rd        <= '0;
            r_ex_a         <= '0;
            r_ex_b         <= '0;
            r_ex_imm       <= '0;
            r_ex_reg_wen   <= 1'b0;
            r_ex_mem_read  <= 1'b0;
            r_ex_mem_write <= 1'b0;
            r_ex_pc_next   <= '0;
        end else begin
            r_ex_valid     <= 1'b1;
            r_ex_op        <= w_op;
            r_ex_rd        <= w_rd;
            r_ex_a         <= w_a;
            r_ex_b         <= RData2;
            r_ex_imm       <= w_imm;
            r_ex_reg_wen   <= w_reg_wen;
            r_ex_mem_read  <= w_mem_read;
            r_ex_mem_write <= w_mem_write;
            r_ex_pc_next   <= IfPcNext;
        end
    end

    assign ExValid    = r_ex_valid;
    assign ExOp       = r_ex_op;
    assign ExRd       = r_ex_rd;
    assign ExA        = r_ex_a;
    assign ExB        = r_ex_b;
    assign ExImm      = r_ex_imm;
    assign ExRegWen   = r_ex_reg_wen;
    assign ExMemRead  = r_ex_mem_read;
    assign ExMemWrite = r_ex_mem_write;
    assign ExPcNext   = r_ex_pc_next;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage: a behavioural model of the
//            EX slot plus directed vectors with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic        Clock;
    logic        Reset;
    logic [15:0] IfInstr;
    logic        IfValid;
    logic [15:0] IfPcNext;
    logic        Flush;
    logic [3:0]  RAddr1;
    logic [3:0]  RAddr2;
    logic [15:0] RData1;
    logic [15:0] RData2;
    logic        Stall;
    logic        ExValid;
    logic [3:0]  ExOp;
    logic [3:0]  ExRd;
    logic [15:0] ExA;
    logic [15:0] ExB;
    logic [15:0] ExImm;
    logic        ExRegWen;
    logic        ExMemRead;
    logic        ExMemWrite;
    logic [15:0] ExPcNext;

    int checks   = 0;
    int failures = 0;

    id_ex_stage #(.DSIZE(16), .RSIZE(4), .ASIZE(16)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .IfInstr    (IfInstr),
        .IfValid    (IfValid),
        .IfPcNext   (IfPcNext),
        .Flush      (Flush),
        .RAddr1     (RAddr1),
        .RAddr2     (RAddr2),
        .RData1     (RData1),
        .RData2     (RData2),
        .Stall      (Stall),
        .ExValid    (ExValid),
        .ExOp       (ExOp),
        .ExRd       (ExRd),
        .ExA        (ExA),
        .ExB        (ExB),
        .ExImm      (ExImm),
        .ExRegWen   (ExRegWen),
        .ExMemRead  (ExMemRead),
        .ExMemWrite (ExMemWrite),
        .ExPcNext   (ExPcNext)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int valid; int op; int rd; int a; int b; int imm;
        int wen; int mr; int mw; int pc;
    } ex_t;

    ex_t m;
    ex_t nxt;

    function automatic int sext(input int v, input int bits);
        if (v >= (1 << (bits - 1))) return (v - (1 << bits)) & 32'hFFFF;
        return v;
    endfunction

    function automatic ex_t bubble_ex();
        ex_t e;
        e = '{default: 0};
        return e;
    endfunction

    function automatic ex_t model_decode(input int ins, input int pc, input int d1, input int d2);
        ex_t e;
        int op;
        int rd;
        op = (ins >> 12) & 15;
        rd = (ins >> 8) & 15;
        e = '{default: 0};
        e.valid = 1;
        e.op    = op;
        e.rd    = (op == 14) ? 15 : rd;
        e.a     = (op == 14) ? pc : d1;
        e.b     = d2;
        e.pc    = pc;
        if (op == 8 || op == 9 || op == 12)       e.imm = sext(ins & 15, 4);
        else if (op >= 4 && op <= 7)              e.imm = ins & 15;
        else if (op == 10 || op == 11)            e.imm = ins & 255;
        else if (op == 13 || op == 14)            e.imm = sext(ins & 4095, 12);
        e.wen = ((op <= 8 || op == 10 || op == 11 || op == 14) && e.rd != 0) ? 1 : 0;
        e.mr  = (op == 8) ? 1 : 0;
        e.mw  = (op == 9) ? 1 : 0;
        return e;
    endfunction

    // Compare process: combinational outputs mid-cycle, EX register after each edge.
    initial begin
        int ins; int op; int rd; int rs1; int rs2; int ra2;
        bit u1; bit u2; bit st;
        m = bubble_ex();
        forever begin
            @(negedge Clock);
            #3;
            if (Reset !== 1'b1) m = bubble_ex();
            ins = int'(IfInstr);
            op  = (ins >> 12) & 15;
            rd  = (ins >> 8) & 15;
            rs1 = (ins >> 4) & 15;
            rs2 = ins & 15;
            ra2 = (op == 9 || op == 12) ? rd : rs2;
            u1  = (op <= 9 || op == 12);
            u2  = (op <= 3 || op == 9 || op == 12);
            st  = (m.valid != 0) && (m.mr != 0) && (m.rd != 0) && (IfValid === 1'b1) &&
                  ((u1 && m.rd == rs1) || (u2 && m.rd == ra2)) && (Flush !== 1'b1);
            chk("m_raddr1", 32'(RAddr1), rs1);
            chk("m_raddr2", 32'(RAddr2), ra2);
            chk("m_stall", 32'(Stall), 32'(st));
            if (Flush === 1'b1 || st || IfValid !== 1'b1) nxt = bubble_ex();
            else nxt = model_decode(ins, int'(IfPcNext), int'(RData1), int'(RData2));
            @(posedge Clock);
            #1;
            m = (Reset !== 1'b1) ? bubble_ex() : nxt;
            chk("m_valid", 32'(ExValid), m.valid);
            chk("m_op", 32'(ExOp), m.op);
            chk("m_rd", 32'(ExRd), m.rd);
            chk("m_a", 32'(ExA), m.a);
            chk("m_b", 32'(ExB), m.b);
            chk("m_imm", 32'(ExImm), m.imm);
            chk("m_regwen", 32'(ExRegWen), m.wen);
            chk("m_memread", 32'(ExMemRead), m.mr);
            chk("m_memwrite", 32'(ExMemWrite), m.mw);
            chk("m_pcnext", 32'(ExPcNext), m.pc);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [15:0] ins(input int op, input int rd, input int rs1, input int rs2);
        return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0]};
    endfunction

    task automatic set_in(input logic [15:0] i, input logic v, input logic [15:0] pc,
                          input logic f, input logic [15:0] d1, input logic [15:0] d2);
        IfInstr  = i;
        IfValid  = v;
        IfPcNext = pc;
        Flush    = f;
        RData1   = d1;
        RData2   = d2;
    endtask

    task automatic step(input logic [15:0] i, input logic v, input logic [15:0] pc,
                        input logic f, input logic [15:0] d1, input logic [15:0] d2);
        @(negedge Clock);
        set_in(i, v, pc, f, d1, d2);
    endtask

    task automatic after_edge();
        @(posedge Clock);
        #2;
    endtask

    initial begin
        Reset = 1'b1;
        set_in(16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        #2 Reset = 1'b0;
        repeat (2) @(posedge Clock);
        #2;
        chk("rst_exvalid", 32'(ExValid), 0);
        chk("rst_stall", 32'(Stall), 0);

        // ADD R3,R1,R2
        @(negedge Clock);
        Reset = 1'b1;
        set_in(ins(0, 3, 1, 2), 1'b1, 16'h0001, 1'b0, 16'h0005, 16'h0007);
        after_edge();
        chk("add_valid", 32'(ExValid), 1);
        chk("add_op", 32'(ExOp), 0);
        chk("add_rd", 32'(ExRd), 3);
        chk("add_a", 32'(ExA), 5);
        chk("add_b", 32'(ExB), 7);
        chk("add_wen", 32'(ExRegWen), 1);

        // LW R4,[R1+2] then dependent ADD R5,R4,R2
        step(ins(8, 4, 1, 2), 1'b1, 16'h0002, 1'b0, 16'h0100, 16'h0000);
        after_edge();
        chk("lw_imm", 32'(ExImm), 32'h0002);
        chk("lw_memread", 32'(ExMemRead), 1);
        step(ins(0, 5, 4, 2), 1'b1, 16'h0003, 1'b0, 16'h0009, 16'h0007);
        #4 chk("lu_stall", 32'(Stall), 1);
        after_edge();
        chk("lu_bubble", 32'(ExValid), 0);
        step(ins(0, 5, 4, 2), 1'b1, 16'h0003, 1'b0, 16'h0009, 16'h0007);
        #4 chk("lu_stall_clear", 32'(Stall), 0);
        after_edge();
        chk("lu_add_valid", 32'(ExValid), 1);
        chk("lu_add_rd", 32'(ExRd), 5);

        // LW R0 then ADD R5,R0,R2: no hazard, no write
        step(ins(8, 0, 1, 3), 1'b1, 16'h0004, 1'b0, 16'h0001, 16'h0000);
        after_edge();
        chk("lw0_wen", 32'(ExRegWen), 0);
        step(ins(0, 5, 0, 2), 1'b1, 16'h0005, 1'b0, 16'h0000, 16'h0007);
        #4 chk("lw0_stall", 32'(Stall), 0);
        after_edge();

        // JAL imm=0xFFE
        step(16'hEFFE, 1'b1, 16'h0010, 1'b0, 16'h1234, 16'h0000);
        after_edge();
        chk("jal_rd", 32'(ExRd), 15);
        chk("jal_a", 32'(ExA), 32'h0010);
        chk("jal_imm", 32'(ExImm), 32'hFFFE);
        chk("jal_wen", 32'(ExRegWen), 1);

        // LW R6 then SW R6,[R2+1]: hazard through the rd-on-port2 path
        step(ins(8, 6, 1, 0), 1'b1, 16'h0011, 1'b0, 16'h0020, 16'h0000);
        step(ins(9, 6, 2, 1), 1'b1, 16'h0012, 1'b0, 16'h0030, 16'h0044);
        #4 chk("sw_raddr2", 32'(RAddr2), 6);
        chk("sw_stall", 32'(Stall), 1);
        step(ins(9, 6, 2, 1), 1'b1, 16'h0012, 1'b0, 16'h0030, 16'h0044);
        after_edge();
        chk("sw_memwrite", 32'(ExMemWrite), 1);
        chk("sw_imm", 32'(ExImm), 1);

        // Hazard and Flush together
        step(ins(8, 6, 1, 0), 1'b1, 16'h0013, 1'b0, 16'h0020, 16'h0000);
        step(ins(9, 6, 2, 1), 1'b1, 16'h0014, 1'b1, 16'h0030, 16'h0044);
        #4 chk("flush_stall", 32'(Stall), 0);
        after_edge();
        chk("flush_bubble", 32'(ExValid), 0);

        // Immediate classes
        step(ins(4, 7, 1, 15), 1'b1, 16'h0015, 1'b0, 16'h00FF, 16'h0000);
        after_edge();
        chk("sll_imm", 32'(ExImm), 32'h000F);
        step(ins(12, 3, 1, 14), 1'b1, 16'h0016, 1'b0, 16'h0001, 16'h0002);
        #4 chk("br_raddr2", 32'(RAddr2), 3);
        after_edge();
        chk("br_imm", 32'(ExImm), 32'hFFFE);
        chk("br_wen", 32'(ExRegWen), 0);
        step(ins(10, 2, 10, 5), 1'b1, 16'h0017, 1'b0, 16'h0000, 16'h0000);
        after_edge();
        chk("lhb_imm", 32'(ExImm), 32'h00A5);
        step(16'hD7FF, 1'b1, 16'h0018, 1'b0, 16'h0000, 16'h0000);
        after_edge();
        chk("j_imm", 32'(ExImm), 32'h07FF);
        chk("j_wen", 32'(ExRegWen), 0);
        step(16'hF000, 1'b1, 16'h0019, 1'b0, 16'h0000, 16'h0000);
        after_edge();
        chk("hlt_op", 32'(ExOp), 15);
        chk("hlt_valid", 32'(ExValid), 1);
        step(16'h0123, 1'b0, 16'h001A, 1'b0, 16'h0000, 16'h0000);
        after_edge();
        chk("novalid_bubble", 32'(ExValid), 0);

        // Asynchronous reset with a valid instruction in EX
        step(ins(1, 3, 1, 2), 1'b1, 16'h0020, 1'b0, 16'h0055, 16'h0011);
        after_edge();
        chk("prerst_valid", 32'(ExValid), 1);
        @(negedge Clock);
        #2 Reset = 1'b0;
        #1;
        chk("arst_valid", 32'(ExValid), 0);
        chk("arst_a", 32'(ExA), 0);
        chk("arst_rd", 32'(ExRd), 0);
        chk("arst_pc", 32'(ExPcNext), 0);
        @(negedge Clock);
        Reset = 1'b1;
        set_in(ins(0, 1, 2, 3), 1'b1, 16'h0021, 1'b0, 16'h0003, 16'h0004);
        after_edge();
        chk("release_valid", 32'(ExValid), 1);

        // Random traffic on a small register set so loads and uses collide
        repeat (60) begin
            step(ins($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3)),
                 1'($urandom_range(0, 7) != 0), 16'($urandom), 1'($urandom_range(0, 7) == 0),
                 16'($urandom), 16'($urandom));
        end
        repeat (2) @(posedge Clock);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters SHALL be: DSIZE, default 16, datapath width; RSIZE, default 4, register address width; ASIZE, default 16, PC width.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-low reset; clears all state when 0.
REQ-004 IfInstr  input  DSIZE  instruction from IF/ID: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4.
REQ-005 IfValid  input  1  IfInstr holds a real instruction.
REQ-006 IfPcNext  input  ASIZE  PC+1 of IfInstr.
REQ-007 Flush  input  1  branch/jump resolved taken in EX; squash the decode slot.
REQ-008 RAddr1, RAddr2  output  RSIZE  register-file read addresses, combinational from IfInstr.
REQ-009 RData1, RData2  input  DSIZE  register-file read data, same cycle as RAddr1/RAddr2.
REQ-010 Stall  output  1  combinational; hold PC and IF/ID this cycle.
REQ-011 ExValid, ExOp[3:0], ExRd[RSIZE-1:0], ExA[DSIZE-1:0], ExB[DSIZE-1:0], ExImm[DSIZE-1:0], ExRegWen, ExMemRead, ExMemWrite, ExPcNext[ASIZE-1:0]  output  registered ID/EX fields.

Function
REQ-012 RAddr1 SHALL be rs1; RAddr2 SHALL be rd for SW (opcode 9) and BR (opcode 12), else rs2.
REQ-013 Opcode classes SHALL be: 0-7 ALU reg-reg (ADD,SUB,AND,OR,SLL,SRL,SRA,RL); 8 LW; 9 SW; 10 LHB; 11 LLB; 12 BR; 13 J; 14 JAL; 15 HLT.
REQ-014 ExImm SHALL be: sign-extended imm4 for LW/SW/BR; zero-extended imm4 for SLL/SRL/SRA/RL; {8'b0,instr[7:0]} for LHB/LLB; sign-extended instr[11:0] for J/JAL.
REQ-015 ExRegWen SHALL be 1 for opcodes 0-8, 10, 11, 14 with nonzero destination, else 0; writes to R0 never assert ExRegWen.
REQ-016 JAL SHALL latch ExRd=15 and ExA=IfPcNext (zero-extended/truncated to DSIZE); all other opcodes latch ExRd=rd.
REQ-017 ExMemRead=1 only for LW; ExMemWrite=1 only for SW.
REQ-018 Load-use hazard SHALL be: ExValid & ExMemRead & ExRd!=0 & IfValid & (ExRd==RAddr1 used | ExRd==RAddr2 used), where "used" follows the opcode's source-operand usage (LHB/LLB use rd as source via RAddr2 path only if opcode 10/11 reads rd; J/JAL/HLT use none).
REQ-019 Stall SHALL equal the load-use hazard and SHALL be forced 0 when Flush=1.
REQ-020 Each rising edge: if Flush or Stall or !IfValid, load a bubble (ExValid=0, ExRegWen=0, ExMemRead=0, ExMemWrite=0, other fields don't-care but held at 0); else latch decoded fields with ExValid=1.
REQ-021 Latency SHALL be one cycle from IfInstr/RData sample to Ex* outputs.
REQ-022 A stall SHALL last exactly one cycle per LW; the bubble clears the hazard on the next edge.
REQ-023 Flush and hazard in the same cycle: Flush wins, bubble inserted, Stall=0.
REQ-024 HLT SHALL pass through as ExOp=15, ExValid=1, no write enables; no internal halt state.

Reset
REQ-025 While Reset=0 all Ex* outputs SHALL be 0 (ExValid=0); Stall SHALL be 0 since ExValid=0.
REQ-026 Reset deassertion mid-program SHALL resume with a bubble in EX; first valid instruction latches on the first edge after release.

Structure
REQ-027 Opcode encodings, class predicates and DSIZE/RSIZE/ASIZE defaults SHALL live in the shared define package used by the register file.
REQ-028 One sub-module id_decode (combinational: instruction -> RAddr, immediate, control bits, operand-use flags) SHALL be instantiated; hazard logic and the ID/EX register stay in id_ex_stage.

Verification
REQ-029 ADD R3,R1,R2 with RData1=0x0005,RData2=0x0007 -> next edge ExValid=1, ExOp=0, ExRd=3, ExA=5, ExB=7, ExRegWen=1.
REQ-030 LW R4,[R1+2] then ADD R5,R4,R2 -> Stall=1 for one cycle, bubble in EX, ADD latched one cycle later; ExImm of LW = 0x0002.
REQ-031 LW R0 then ADD R5,R0,R2 -> Stall=0; LW with ExRd=0 has ExRegWen=0.
REQ-032 JAL imm=0xFFE, IfPcNext=0x0010 -> ExRd=15, ExA=0x0010, ExImm=0xFFFE, ExRegWen=1.
REQ-033 Hazard present and Flush=1 same cycle -> Stall=0, ExValid=0 next edge.
REQ-034 Reset asserted asynchronously mid-cycle with ExValid=1 -> all Ex* 0 immediately, without a clock edge.
